// File: rtl/pulse_tracer.sv
// Detects isolated high runs of exactly PULSE_WIDTH cycles on an asynchronous input.
// Latency: strobe rises SYNC_STAGES edges after the edge that samples the terminating low.
// Backpressure: none; the strobe is a free-running one-cycle pulse with no ready handshake.
module pulse_tracer #(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_WIDTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic noisy_in,
    output logic pulse_detected
);

    localparam int CNT_W = $clog2(PULSE_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PULSE_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(PULSE_WIDTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       run_cnt;
    logic [CNT_W-1:0]       run_cnt_nxt;
    logic                   hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Saturating one past the target keeps over-long runs from ever matching again.
    always_comb begin
        run_cnt_nxt = '0;
        if (s) begin
            if (run_cnt == CNT_MAX) begin
                run_cnt_nxt = run_cnt;
            end else begin
                run_cnt_nxt = run_cnt + CNT_W'(1);
            end
        end
    end

    assign hit = !s && (run_cnt == CNT_HIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt        <= '0;
            pulse_detected <= 1'b0;
        end else begin
            run_cnt        <= run_cnt_nxt;
            pulse_detected <= hit;
        end
    end

endmodule

// File: tb/tb_pulse_tracer.sv
// Self-checking bench for pulse_tracer with default parameters.
module tb_pulse_tracer;

    logic clk = 1'b0;
    logic rst;
    logic noisy_in;
    logic pulse_detected;

    always #5 clk = ~clk;

    pulse_tracer #(
        .SYNC_STAGES(2),
        .PULSE_WIDTH(1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .noisy_in      (noisy_in),
        .pulse_detected(pulse_detected)
    );

    int   n_applied     = 0;
    int   n_miscompares = 0;
    logic exp_q[$];

    typedef struct {
        string       name;
        int          len;
        logic [31:0] pat;   // bit i: noisy_in during cycle i
        logic [31:0] exp;   // bit i: pulse_detected after edge i
    } vec_t;

    vec_t vecs[8];

    // Drive one cycle from a negedge, expect a value after the following posedge.
    task automatic step(input logic r, input logic d, input logic e, input string tag);
        logic want;
        rst      = r;
        noisy_in = d;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        want = exp_q.pop_front();
        n_applied++;
        if (pulse_detected !== want) begin
            n_miscompares++;
            $display("FAIL %s: pulse_detected=%b expected %b", tag, pulse_detected, want);
        end
    endtask

    task automatic do_reset(input string tag);
        step(1'b1, 1'b0, 1'b0, {tag, "_rst0"});
        step(1'b1, 1'b0, 1'b0, {tag, "_rst1"});
    endtask

    initial begin
        vecs[0] = '{"single",       8, 32'h0000_0002, 32'h0000_0010};
        vecs[1] = '{"double",      10, 32'h0000_0006, 32'h0000_0000};
        vecs[2] = '{"alternating", 12, 32'h0000_0015, 32'h0000_00A8};
        vecs[3] = '{"triple",      10, 32'h0000_000E, 32'h0000_0000};
        vecs[4] = '{"single_dbl",  12, 32'h0000_001A, 32'h0000_0010};
        vecs[5] = '{"dbl_single",  12, 32'h0000_000B, 32'h0000_0040};
        vecs[6] = '{"spaced",      14, 32'h0000_0044, 32'h0000_0220};
        vecs[7] = '{"first_cycle",  8, 32'h0000_0001, 32'h0000_0008};

        rst      = 1'b1;
        noisy_in = 1'b0;
        @(negedge clk);

        do_reset("init");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, $sformatf("post_reset_%0d", i));

        foreach (vecs[v]) begin
            do_reset(vecs[v].name);
            for (int i = 0; i < vecs[v].len; i++) begin
                step(1'b0, vecs[v].pat[i], vecs[v].exp[i], $sformatf("%s_c%0d", vecs[v].name, i));
            end
        end

        // Long highs must neither strobe nor wrap the run counter into a false match.
        for (int n = 300; n <= 301; n++) begin
            do_reset($sformatf("sustain%0d", n));
            step(1'b0, 1'b0, 1'b0, $sformatf("sustain%0d_lead", n));
            for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, $sformatf("sustain%0d_hi%0d", n, i));
            for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, $sformatf("sustain%0d_lo%0d", n, i));
        end

        // Reset landing 1..3 edges after a valid high discards it; a later pulse still works.
        for (int d = 1; d <= 3; d++) begin
            do_reset($sformatf("abort%0d", d));
            step(1'b0, 1'b0, 1'b0, $sformatf("abort%0d_lead", d));
            step(1'b0, 1'b1, 1'b0, $sformatf("abort%0d_hi", d));
            for (int i = 1; i < d; i++) step(1'b0, 1'b0, 1'b0, $sformatf("abort%0d_gap%0d", d, i));
            step(1'b1, 1'b0, 1'b0, $sformatf("abort%0d_r0", d));
            step(1'b1, 1'b0, 1'b0, $sformatf("abort%0d_r1", d));
            for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, $sformatf("abort%0d_quiet%0d", d, i));
            step(1'b0, 1'b1, 1'b0, $sformatf("abort%0d_re_hi", d));
            step(1'b0, 1'b0, 1'b0, $sformatf("abort%0d_re_l1", d));
            step(1'b0, 1'b0, 1'b0, $sformatf("abort%0d_re_l2", d));
            step(1'b0, 1'b0, 1'b1, $sformatf("abort%0d_re_strobe", d));
            step(1'b0, 1'b0, 1'b0, $sformatf("abort%0d_re_after", d));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pulse_tracer.md
PULSE_TRACER -- requirements
Module: pulse_tracer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of input synchronizer flops, legal range 2..4.
REQ-002 Parameter PULSE_WIDTH, default 1: exact high-run length, in clk cycles, that counts as a valid pulse; legal range 1..255.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port noisy_in, input, 1 bit: asynchronous, possibly glitchy level input to be monitored.
REQ-006 Port pulse_detected, output, 1 bit, registered: one-cycle strobe flagging a valid pulse.

Function
REQ-007 noisy_in SHALL pass through a SYNC_STAGES-deep flop chain; the last stage output, s, is the only value used by the detection logic.
REQ-008 A run counter SHALL reset to 0 on every cycle where s=0, and increment on every cycle where s=1.
REQ-009 The run counter SHALL saturate at PULSE_WIDTH+1 and never wrap; width SHALL be clog2(PULSE_WIDTH+2) bits.
REQ-010 A valid pulse SHALL be a run of s=1 of exactly PULSE_WIDTH cycles, bounded by s=0 before and after it.
REQ-011 pulse_detected SHALL be registered high for exactly one cycle on the clock edge where s=0 and the run counter equals PULSE_WIDTH.
REQ-012 Runs shorter or longer than PULSE_WIDTH, including any run held high indefinitely, SHALL NOT assert pulse_detected.
REQ-013 Latency: pulse_detected SHALL rise SYNC_STAGES rising edges after the edge that first samples noisy_in low following the run (3 edges after the edge sampling the high, with defaults).
REQ-014 Back-to-back valid pulses separated by a single low cycle SHALL each produce a separate one-cycle strobe.
REQ-015 The low cycle that terminates one run SHALL also serve as the leading low of the next run.
REQ-016 pulse_detected SHALL never be high on two consecutive cycles.
REQ-017 The block SHALL contain no combinational path from noisy_in to pulse_detected.

Reset
REQ-018 While rst=1 at a rising edge, all synchronizer flops, the run counter and pulse_detected SHALL be cleared to 0.
REQ-019 After release, the cleared synchronizer SHALL count as the leading low, so the first run after reset is eligible for detection.
REQ-020 Reset asserted mid-run or mid-latency SHALL discard that run, with no strobe after release for any run begun before reset.
REQ-021 Reset SHALL take precedence over every other update in the same cycle.

Verification
REQ-022 Reset: rst=1 for 2 cycles with noisy_in=0 -> pulse_detected=0 throughout, and 0 after release.
REQ-023 One-cycle pulse: noisy_in=1 for exactly 1 cycle (defaults) -> pulse_detected=1 for exactly 1 cycle, 3 edges after the high was sampled.
REQ-024 Two-cycle pulse: noisy_in=1 for 2 cycles, then 0 -> pulse_detected stays 0.
REQ-025 Sustained high: noisy_in=1 for 300 cycles, then 0 -> pulse_detected stays 0 and the counter does not wrap.
REQ-026 Alternating pattern: 1,0,1,0,1,0 -> three separate one-cycle strobes spaced 2 cycles apart.
REQ-027 Reset abort: one-cycle pulse, then rst=1 on the next edge -> no strobe after release.
